// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: opcodes,
// FSM state encodings, datapath mux encodings and the opcode class bundle.
package multicycle_ctrl_pkg;

  // Major opcodes, ir[6:2]; the immediate generator keys off the same values
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam logic [4:0] OP_ARITHI = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ARITHR = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  // Every 32-bit RV32I encoding carries 2'b11 in its two lowest bits
  localparam logic [1:0] QUADRANT_32 = 2'b11;

  // Controller states; the register is 3 bits wide, so 6 and 7 are unused
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Next-PC source select
  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_sel_t;

  // Register file write-back source select
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_t;

  // One-hot-ish classification of the current instruction
  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_alu_reg;
    logic is_alu_imm;
    logic is_lui;
    logic is_auipc;
    logic is_fence;
    logic is_sys;
    logic is_illegal;
  } op_class_t;

  // Extract the major opcode field from an instruction word
  function automatic logic [4:0] ir_opcode(input logic [31:0] instr);
    return instr[6:2];
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the FSM and the datapath/memory port.
// The controller is the master: it consumes status and drives every enable/select.
interface multicycle_ctrl_if;

  // Status from the datapath and memory
  logic [31:0] ir;
  logic        branch_taken;
  logic        mem_ready;

  // Datapath enables and selects
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        ir_we;
  logic        ab_we;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;

  // Core status
  logic        instr_done;
  logic        halted;
  logic        illegal;

  modport master (
    input  ir, branch_taken, mem_ready,
    output pc_we, pc_sel, ir_we, ab_we, alu_a_sel, alu_b_sel,
           mem_req, mem_we, mem_addr_sel, rf_we, wb_sel,
           instr_done, halted, illegal
  );

  modport slave (
    output ir, branch_taken, mem_ready,
    input  pc_we, pc_sel, ir_we, ab_we, alu_a_sel, alu_b_sel,
           mem_req, mem_we, mem_addr_sel, rf_we, wb_sel,
           instr_done, halted, illegal
  );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Opcode classifier: turns the instruction word into a set of class flags.
// Anything outside the supported RV32I subset is flagged illegal.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output op_class_t   op
);

  logic [4:0] opcode;
  logic       unused_ir_fields;

  assign opcode = ir_opcode(ir);

  // Register/immediate fields belong to the datapath, not the controller
  assign unused_ir_fields = ^ir[31:7];

  // Classify the opcode; a wrong quadrant overrides everything else
  always_comb begin
    op = '0;
    if (ir[1:0] != QUADRANT_32) begin
      op.is_illegal = 1'b1;
    end else begin
      case (opcode)
        OP_LOAD:   op.is_load    = 1'b1;
        OP_STORE:  op.is_store   = 1'b1;
        OP_BRANCH: op.is_branch  = 1'b1;
        OP_JAL:    op.is_jal     = 1'b1;
        OP_JALR:   op.is_jalr    = 1'b1;
        OP_ARITHR: op.is_alu_reg = 1'b1;
        OP_ARITHI: op.is_alu_imm = 1'b1;
        OP_LUI:    op.is_lui     = 1'b1;
        OP_AUIPC:  op.is_auipc   = 1'b1;
        OP_FENCE:  op.is_fence   = 1'b1;
        OP_SYSTEM: op.is_sys     = 1'b1;
        default:   op.is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// One instruction at a time walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Fetch and load/store share one memory port, so both use the same
// mem_req/mem_ready handshake; a raised request is held until mem_ready.
// Outputs are Mealy: they depend on state, the decoded IR, branch_taken and
// mem_ready, so zero-wait memory completes in the cycle the request is made.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  state_t    state;
  state_t    state_nxt;
  op_class_t op;
  logic      illegal_q;
  logic      illegal_set;

  // Raw combinational controls, gated by reset before leaving the block
  logic       pc_we_c;
  pc_sel_t    pc_sel_c;
  logic       ir_we_c;
  logic       ab_we_c;
  logic       alu_a_sel_c;
  logic       alu_b_sel_c;
  logic       mem_req_c;
  logic       mem_we_c;
  logic       mem_addr_sel_c;
  logic       rf_we_c;
  wb_sel_t    wb_sel_c;
  logic       instr_done_c;

  multicycle_ctrl_decode u_decode (
    .ir (bus.ir),
    .op (op)
  );

  // State register; reset lands in FETCH from any state, including mid-access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= state_t'(RESET_STATE);
    end else begin
      state <= state_nxt;
    end
  end

  // Halt cause: set only when DECODE rejects an instruction, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (illegal_set) begin
      illegal_q <= 1'b1;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nxt      = state;
    illegal_set    = 1'b0;
    pc_we_c        = 1'b0;
    pc_sel_c       = PC_PLUS4;
    ir_we_c        = 1'b0;
    ab_we_c        = 1'b0;
    alu_a_sel_c    = 1'b0;
    alu_b_sel_c    = 1'b0;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    rf_we_c        = 1'b0;
    wb_sel_c       = WB_ALU;
    instr_done_c   = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b0;
        if (bus.mem_ready) begin
          ir_we_c   = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        ab_we_c = 1'b1;
        if (op.is_illegal) begin
          illegal_set = 1'b1;
          state_nxt   = S_HALT;
        end else if (op.is_sys) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        if (op.is_alu_reg) begin
          state_nxt = S_WB;
        end else if (op.is_alu_imm) begin
          alu_b_sel_c = 1'b1;
          state_nxt   = S_WB;
        end else if (op.is_load || op.is_store) begin
          alu_b_sel_c = 1'b1;
          state_nxt   = S_MEM;
        end else if (op.is_lui) begin
          state_nxt = S_WB;
        end else if (op.is_auipc) begin
          alu_a_sel_c = 1'b1;
          alu_b_sel_c = 1'b1;
          state_nxt   = S_WB;
        end else if (op.is_branch) begin
          pc_we_c      = 1'b1;
          pc_sel_c     = bus.branch_taken ? PC_IMM : PC_PLUS4;
          instr_done_c = 1'b1;
          state_nxt    = S_FETCH;
        end else if (op.is_jal) begin
          rf_we_c      = 1'b1;
          wb_sel_c     = WB_PC4;
          pc_we_c      = 1'b1;
          pc_sel_c     = PC_IMM;
          instr_done_c = 1'b1;
          state_nxt    = S_FETCH;
        end else if (op.is_jalr) begin
          alu_b_sel_c  = 1'b1;
          rf_we_c      = 1'b1;
          wb_sel_c     = WB_PC4;
          pc_we_c      = 1'b1;
          pc_sel_c     = PC_ALU;
          instr_done_c = 1'b1;
          state_nxt    = S_FETCH;
        end else if (op.is_fence) begin
          pc_we_c      = 1'b1;
          pc_sel_c     = PC_PLUS4;
          instr_done_c = 1'b1;
          state_nxt    = S_FETCH;
        end else begin
          // Only reachable if IR changed under us after DECODE; stop safely
          illegal_set = 1'b1;
          state_nxt   = S_HALT;
        end
      end

      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = op.is_store;
        if (bus.mem_ready) begin
          if (op.is_store) begin
            pc_we_c      = 1'b1;
            pc_sel_c     = PC_PLUS4;
            instr_done_c = 1'b1;
            state_nxt    = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we_c      = 1'b1;
        pc_we_c      = 1'b1;
        pc_sel_c     = PC_PLUS4;
        instr_done_c = 1'b1;
        if (op.is_load) begin
          wb_sel_c = WB_MEM;
        end else if (op.is_lui) begin
          wb_sel_c = WB_IMM;
        end else begin
          wb_sel_c = WB_ALU;
        end
        state_nxt = S_FETCH;
      end

      S_HALT: begin
        state_nxt = S_HALT;
      end

      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // While reset is high the state already reads FETCH; gating keeps an
  // abandoned fetch from presenting a request or strobing any enable.
  assign bus.mem_req      = mem_req_c    & ~rst;
  assign bus.mem_we       = mem_we_c     & ~rst;
  assign bus.ir_we        = ir_we_c      & ~rst;
  assign bus.ab_we        = ab_we_c      & ~rst;
  assign bus.pc_we        = pc_we_c      & ~rst;
  assign bus.rf_we        = rf_we_c      & ~rst;
  assign bus.instr_done   = instr_done_c & ~rst;
  assign bus.mem_addr_sel = mem_addr_sel_c;
  assign bus.alu_a_sel    = alu_a_sel_c;
  assign bus.alu_b_sel    = alu_b_sel_c;
  assign bus.pc_sel       = pc_sel_c;
  assign bus.wb_sel       = wb_sel_c;
  assign bus.halted       = (state == S_HALT);
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each directed instruction pushes its
// hand-computed retire/halt expectation; a monitor pops and compares whenever
// the controller retires (instr_done) or enters HALT.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.RESET_STATE(3'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ctl = {rf_we, wb_sel[1:0], pc_we, pc_sel[1:0], alu_b_sel, mem_we}
  typedef struct {
    bit         isHalt;
    int         lat;
    logic [7:0] ctl;
    logic       ill;
    string      name;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  int   cycInInstr = 0;
  logic prevHalted = 1'b0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic exp_t mkRet(input string name, input int lat, input logic rf,
                                 input logic [1:0] wb, input logic [1:0] ps,
                                 input logic ab, input logic mw);
    exp_t e;
    e.isHalt = 1'b0;
    e.lat    = lat;
    e.ctl    = {rf, wb, 1'b1, ps, ab, mw};
    e.ill    = 1'b0;
    e.name   = name;
    return e;
  endfunction

  function automatic exp_t mkHalt(input string name, input logic ill);
    exp_t e;
    e.isHalt = 1'b1;
    e.lat    = 3;
    e.ctl    = 8'h00;
    e.ill    = ill;
    e.name   = name;
    return e;
  endfunction

  // Monitor: measures cycles since reset/last retire and scores each event
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cycInInstr = 0;
        prevHalted = 1'b0;
      end else begin
        cycInInstr++;
        if (bus.instr_done === 1'b1 || (bus.halted === 1'b1 && !prevHalted)) begin
          if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_event: got done=%b halted=%b expected no event",
                     bus.instr_done, bus.halted);
          end else begin
            e = expQ.pop_front();
            checkOutput({e.name, "_kind"}, {7'd0, bus.halted}, {7'd0, e.isHalt});
            checkOutput({e.name, "_lat"}, 8'(cycInInstr), 8'(e.lat));
            if (e.isHalt)
              checkOutput({e.name, "_illegal"}, {7'd0, bus.illegal}, {7'd0, e.ill});
            else
              checkOutput({e.name, "_ctl"},
                          {bus.rf_we, bus.wb_sel, bus.pc_we, bus.pc_sel, bus.alu_b_sel, bus.mem_we},
                          e.ctl);
          end
          if (bus.instr_done === 1'b1) cycInInstr = 0;
        end
        prevHalted = bus.halted;
      end
    end
  end

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs one instruction from reset; mask bit k is mem_ready in cycle k+1
  task automatic applyStimulus(input exp_t e, input logic [31:0] instr, input logic taken,
                               input logic [31:0] mask, input bit memHold);
    bit done = 1'b0;
    expQ.push_back(e);
    doReset();
    bus.ir           = instr;
    bus.branch_taken = taken;
    bus.mem_ready    = mask[0];
    for (int k = 0; k < 32 && !done; k++) begin
      if (k > 0) bus.mem_ready = mask[k];
      @(negedge clk);
      if (memHold && k >= 3 && k <= 6)
        checkOutput("lw_mem_hold", {5'd0, bus.mem_req, bus.mem_addr_sel, bus.mem_we}, 8'b110);
      if (bus.instr_done === 1'b1 || bus.halted === 1'b1) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++;
      $display("[TB] FAIL %s_timeout: got no retire/halt expected one within 32 cycles", e.name);
    end
  endtask

  initial begin
    int reqCnt;
    int notHalted;
    rst              = 1'b1;
    bus.ir           = 32'h0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b0;
    #2;
    checkOutput("reset_outputs",
                {2'd0, bus.halted, bus.illegal, bus.mem_req, bus.pc_we, bus.ir_we, bus.rf_we}, 8'h00);

    applyStimulus(mkRet("addi",       4, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0), 32'h00500093, 1'b0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(mkRet("addi_fwait", 6, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0), 32'h00500093, 1'b0, 32'hFFFF_FFFC, 1'b0);
    applyStimulus(mkRet("add",        4, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0), 32'h002081B3, 1'b0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(mkRet("lui",        4, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0), 32'h000012B7, 1'b0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(mkRet("auipc",      4, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0), 32'h00000097, 1'b0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(mkRet("lw_wait",    8, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0), 32'h0000A103, 1'b0, 32'hFFFF_FFC1, 1'b1);
    applyStimulus(mkRet("sw",         4, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1), 32'h0020A023, 1'b0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(mkRet("beq_taken",  3, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0), 32'h00000463, 1'b1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(mkRet("beq_nt",     3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0), 32'h00000463, 1'b0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(mkRet("jal",        3, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0), 32'h008000EF, 1'b0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(mkRet("jalr",       3, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0), 32'h000280E7, 1'b0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(mkRet("fence",      3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0), 32'h0000000F, 1'b0, 32'hFFFF_FFFF, 1'b0);

    // Wrong quadrant halts as illegal; reset must clear halted/illegal without a clock edge
    applyStimulus(mkHalt("illegal_q00", 1'b1), 32'h00000000, 1'b0, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checkOutput("async_reset_clears_halt", {6'd0, bus.halted, bus.illegal}, 8'h00);
    rst = 1'b0;

    applyStimulus(mkHalt("illegal_op", 1'b1), 32'h00000007, 1'b0, 32'hFFFF_FFFF, 1'b0);

    // ECALL halts cleanly and the core stays silent on the memory port
    applyStimulus(mkHalt("ecall", 1'b0), 32'h00000073, 1'b0, 32'hFFFF_FFFF, 1'b0);
    reqCnt    = 0;
    notHalted = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0) reqCnt++;
      if (bus.halted !== 1'b1) notHalted++;
    end
    checkOutput("halt_no_mem_req", 8'(reqCnt), 8'd0);
    checkOutput("halt_sticky", 8'(notHalted), 8'd0);

    // Reset during a stalled fetch drops the request at once, then refetches
    doReset();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("fetch_wait_req", {6'd0, bus.mem_req, bus.mem_addr_sel}, 8'b10);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_drops_req", {7'd0, bus.mem_req}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("refetch_req", {6'd0, bus.mem_req, bus.mem_addr_sel}, 8'b10);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 8'(expQ.size()), 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
- The core has a single shared memory port, so instruction fetch and load/store are serialised through one request/ready handshake.
- Drives every datapath enable and mux select: PC, IR, A/B operand latches, immediate generator consumer muxes, register file, memory port.

Parameters:
- RESET_STATE, 3'd0, encoding of FETCH; the state register loads this on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir  in  32  current instruction register contents; decoded fields: opcode ir[6:2], ir[1:0].
- branch_taken  in  1  branch comparator result, valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle. May be asserted in the same cycle as mem_req.
- pc_we  out  1  PC load enable.
- pc_sel  out  2  PC source: 00 = PC+4, 01 = PC+imm, 10 = ALU result with bit 0 cleared.
- ir_we  out  1  IR load enable from memory read data.
- ab_we  out  1  latch rs1/rs2 register file outputs into A/B.
- alu_a_sel  out  1  ALU operand A: 0 = A, 1 = PC.
- alu_b_sel  out  1  ALU operand B: 0 = B, 1 = immediate.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write (store).
- mem_addr_sel  out  1  memory address: 0 = PC, 1 = ALU result register.
- rf_we  out  1  register file write enable.
- wb_sel  out  2  write-back source: 00 = ALU, 01 = memory data, 10 = PC+4, 11 = immediate.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  core stopped.
- illegal  out  1  halt cause was an illegal instruction.

Behaviour:
- Reset (asynchronous): state = FETCH; halted = 0, illegal = 0.
- Outputs are combinational from state, ir, branch_taken and mem_ready (Mealy). All outputs not listed for a state are 0.
- FETCH: mem_req = 1, mem_addr_sel = 0.
  - On mem_ready: ir_we = 1, next state DECODE.
  - Otherwise hold FETCH with mem_req held high. Requests are never dropped once raised.
- DECODE: ab_we = 1.
  - If ir[1:0] != 2'b11 or the opcode is unsupported: go to HALT with illegal = 1.
  - Opcode 11100 (ECALL/EBREAK): go to HALT, illegal = 0.
  - Otherwise go to EXEC.
- EXEC, by opcode:
  - Arith_R 01100: alu_a_sel = 0, alu_b_sel = 0 -> WB.
  - Arith_I 00100: alu_b_sel = 1 -> WB.
  - Load 00000 / Store 01000: alu_b_sel = 1 -> MEM.
  - LUI 01101 -> WB.
  - AUIPC 00101: alu_a_sel = 1, alu_b_sel = 1 -> WB.
  - Branch 11000: pc_we = 1, pc_sel = branch_taken ? 01 : 00, instr_done = 1 -> FETCH.
  - JAL 11011: rf_we = 1, wb_sel = 10, pc_we = 1, pc_sel = 01, instr_done = 1 -> FETCH.
  - JALR 11001: alu_b_sel = 1, rf_we = 1, wb_sel = 10, pc_we = 1, pc_sel = 10, instr_done = 1 -> FETCH.
  - FENCE 00011: pc_we = 1, pc_sel = 00, instr_done = 1 -> FETCH.
- MEM: mem_req = 1, mem_addr_sel = 1, mem_we = (opcode == Store).
  - Hold until mem_ready.
  - Load then -> WB.
  - Store then: pc_we = 1, pc_sel = 00, instr_done = 1 -> FETCH.
- WB: rf_we = 1, pc_we = 1, pc_sel = 00, instr_done = 1 -> FETCH.
  - wb_sel: 01 for Load, 11 for LUI, 00 otherwise.
- HALT: absorbing state, halted = 1. Only reset leaves it. No memory requests are issued.
- Latency with zero-wait memory (mem_ready in the same cycle as mem_req):
  - Branch / JAL / JALR / FENCE: 3 cycles.
  - ALU / LUI / AUIPC / Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- rd == x0: the controller still asserts rf_we; the register file ignores the write.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-access (FETCH or MEM wait): mem_req drops immediately; the FSM restarts in FETCH. The memory must tolerate an abandoned request.
- The state register is 3 bits. Unused encodings recover to FETCH on the next clock.

Decomposition:
- Shared package/defines:
  - Opcode constants (5-bit, ir[6:2]), already used by the immediate generator.
  - State encodings: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5.
  - pc_sel and wb_sel encodings.
- Sub-module: none required. Optionally split out an opcode classifier, ctrl_decode, that produces is_load / is_store / is_branch / is_jal / is_jalr / is_alu / is_lui / is_auipc / is_sys / is_illegal.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093), mem_ready always 1 -> states F, D, E, WB. In WB: rf_we = 1, wb_sel = 00, pc_we = 1, pc_sel = 00. instr_done after 4 cycles.
- LW x2,0(x1) (0x0000A103), mem_ready held 0 for 3 cycles in MEM -> mem_req = 1 and mem_addr_sel = 1 held steady throughout. WB wb_sel = 01. Retires after 8 cycles.
- BEQ (0x00000463) with branch_taken = 1 -> EXEC pc_sel = 01. Repeat with branch_taken = 0 -> pc_sel = 00. Both retire in 3 cycles with rf_we = 0.
- JALR x1,0(x5) (0x000280E7) -> EXEC: rf_we = 1, wb_sel = 10, pc_sel = 10, alu_b_sel = 1.
- ir = 0x00000000 (ir[1:0] = 00) -> HALT with illegal = 1. Then ECALL (0x00000073) after reset -> halted = 1, illegal = 0. mem_req stays 0 for 20 further cycles.
- Assert rst during the FETCH wait with mem_req = 1 -> mem_req = 0 within the same cycle. After release, FETCH is re-entered and mem_req = 1 on the next cycle.
